xge_rx_reader: RTL and testbench

Packet-receive drain stage sitting directly downstream of the `xge_mac` `pkt_rx_*` interface. It monitors `pkt_rx_avail` and issues `pkt_rx_ren` reads against the MAC's 1-cycle read latency. It re-times the packet words into a 2-entry output buffer with a valid/ready stream and enforces a maximum packet length. It also maintains packet, error and byte statistics for the bench and for later system use.

---
 rtl/xge_rx_reader_if.sv | 13 +
 rtl/xge_rx_reader.sv | 80 ++++++++
 tb/tb_xge_rx_reader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/xge_rx_reader_if.sv
// xge_rx_reader_if: one packet-word stream, used for both the MAC receive side and the output side
interface xge_rx_reader_if;
   logic        avail;
   logic        val;
   logic        ready;
   logic [63:0] data;
   logic        sop;
   logic        eop;
   logic [2:0]  mod;
   logic        err;
   modport master (output avail, val, data, sop, eop, mod, err, input ready);
   modport slave (input avail, val, data, sop, eop, mod, err, output ready);
endinterface

// File: rtl/xge_rx_reader.sv
// xge_rx_reader: drains xge_mac pkt_rx words into a 2-entry valid/ready buffer with length limit and stats
module xge_rx_reader #(
   parameter int CNT_W     = 32,
   parameter int MAX_WORDS = 190
) (
   input  logic               clk_156m25,
   input  logic               reset_156m25_n,
   xge_rx_reader_if.slave     rx,
   xge_rx_reader_if.master    out,
   output logic [CNT_W-1:0]   pkt_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W-1:0]   byte_cnt
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] READ = 1'b1;
   localparam int IW = $clog2(MAX_WORDS + 1);
   logic [0:0]    state;
   logic          inflight;
   logic [1:0]    occ;
   logic [IW-1:0] idx;
   logic          sticky;
   logic [69:0]   e0;
   logic [69:0]   e1;
   logic          rx_eop;
   logic          accept;
   logic          pop;
   logic          push;
   logic          drop;
   logic          sticky_now;
   logic          wr_hi;
   logic [2:0]    level;
   logic [69:0]   word;
   logic [3:0]    nbytes;
   always_comb begin
      rx_eop     = rx.val && rx.eop;
      accept     = rx.val && state == READ;
      pop        = occ != 2'd0 && out.ready;
      push       = accept && (rx.eop || idx <= IW'(MAX_WORDS - 2));
      drop       = accept && !push;
      sticky_now = sticky || rx.err || drop;
      level      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
      wr_hi      = (occ - {1'b0, pop}) != 2'd0;
      word       = {rx.data, rx.sop, rx.eop, rx.mod, rx.eop ? sticky_now : rx.err};
      nbytes     = (!rx.eop || rx.mod == 3'd0) ? 4'd8 : {1'b0, rx.mod};
   end
   // level counts buffered plus in-flight words after this cycle's pop, so a read never overflows
   assign rx.ready  = state == READ && level < 3'd2 && !rx_eop;
   assign out.val   = occ != 2'd0;
   assign out.avail = occ != 2'd0;
   assign {out.data, out.sop, out.eop, out.mod, out.err} = e0;
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state    <= IDLE;
         inflight <= 1'b0;
         occ      <= 2'd0;
         idx      <= '0;
         sticky   <= 1'b0;
         e0       <= '0;
         e1       <= '0;
         pkt_cnt  <= '0;
         err_cnt  <= '0;
         byte_cnt <= '0;
      end else begin
         state    <= state == IDLE ? (rx.avail ? READ : IDLE) : (rx_eop ? IDLE : READ);
         inflight <= rx.ready;
         occ      <= occ + {1'b0, push} - {1'b0, pop};
         e0       <= (push && !wr_hi) ? word : pop ? e1 : e0;
         if (push && wr_hi) e1 <= word;
         if (accept) begin
            idx      <= rx.eop ? '0 : (idx == IW'(MAX_WORDS) ? idx : idx + 1'b1);
            sticky   <= rx.eop ? 1'b0 : sticky_now;
            byte_cnt <= byte_cnt + CNT_W'(nbytes);
            if (rx.eop) begin
               pkt_cnt <= pkt_cnt + 1'b1;
               err_cnt <= err_cnt + CNT_W'(sticky_now);
            end
         end
      end
   end
endmodule

// File: tb/tb_xge_rx_reader.sv
// tb_xge_rx_reader: directed bench with a MAC read-latency model and an output word scoreboard
module tb_xge_rx_reader;
   localparam int MAXW = 190;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pkt_cnt;
   logic [31:0] err_cnt;
   logic [31:0] byte_cnt;
   xge_rx_reader_if rx_if();
   xge_rx_reader_if out_if();
   xge_rx_reader #(.CNT_W(32), .MAX_WORDS(MAXW)) dut (
      .clk_156m25(clk), .reset_156m25_n(rst_n), .rx(rx_if), .out(out_if),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .byte_cnt(byte_cnt));
   always #5 clk = ~clk;
   int checks = 0;
   int fails = 0;
   logic [69:0] mq[$];
   logic [69:0] expq[$];
   int cyc, ren_cnt, run, max_run, first_ren, first_out, pops, err_pops, mac_given;
   logic [2:0] last_mod;
   logic last_err;
   bit toggle;
   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic clear_stats();
      cyc = 0; ren_cnt = 0; run = 0; max_run = 0; first_ren = -1; first_out = -1;
      pops = 0; err_pops = 0; last_mod = 3'd0; last_err = 1'b0;
   endtask
   // Expected output: words past MAX_WORDS-2 dropped, eop carries the sticky error
   task automatic load_pkt(input int p, input int n, input logic [2:0] m, input int ew);
      logic st = 1'b0;
      for (int i = 0; i < n; i++) begin
         logic eop = (i == n - 1);
         logic er = (i == ew);
         logic dr = !eop && i > MAXW - 2;
         st = st | er | dr;
         mq.push_back({32'(p), 32'(i), i == 0, eop, eop ? m : 3'd0, er});
         if (!dr) expq.push_back({32'(p), 32'(i), i == 0, eop, eop ? m : 3'd0, eop ? st : er});
      end
   endtask
   task automatic tick();
      logic ren_s;
      logic [69:0] w;
      #4;
      ren_s = rx_if.ready;
      if (rx_if.val && rx_if.eop) chk("ren_after_eop", 70'(ren_s), 70'(0));
      if (ren_s) begin
         chk("ren_nonempty", 70'(mq.size() != 0), 70'(1));
         ren_cnt++; run++;
         if (run > max_run) max_run = run;
         if (first_ren < 0) first_ren = cyc;
      end else run = 0;
      if (out_if.val && first_out < 0) first_out = cyc;
      if (out_if.val && out_if.ready) begin
         w = {out_if.data, out_if.sop, out_if.eop, out_if.mod, out_if.err};
         if (expq.size() == 0) chk("extra_word", 70'(expq.size()), 70'(1));
         else chk("word", w, expq.pop_front());
         pops++;
         if (out_if.err) err_pops++;
         if (out_if.eop) begin last_mod = out_if.mod; last_err = out_if.err; end
      end
      cyc++;
      @(posedge clk); #1;
      if (ren_s && mq.size() != 0) begin
         w = mq.pop_front();
         {rx_if.data, rx_if.sop, rx_if.eop, rx_if.mod, rx_if.err} = w;
         rx_if.val = 1'b1;
         mac_given++;
      end else rx_if.val = 1'b0;
      rx_if.avail = mq.size() != 0;
      out_if.ready = toggle ? !out_if.ready : 1'b1;
   endtask
   task automatic run_pkt(input string tag, input int limit);
      int n = 0;
      while ((mq.size() != 0 || expq.size() != 0) && n < limit) begin tick(); n++; end
      checks++;
      assert (n < limit) else begin
         fails++;
         $error("FAIL %s_timeout observed=%0d expected<%0d", tag, n, limit);
      end
      repeat (2) tick();
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 70'({rx_if.ready, out_if.val, out_if.sop, out_if.eop, out_if.mod, out_if.err}), 70'(0));
      chk({tag, "_data"}, 70'(out_if.data), 70'(0));
      chk({tag, "_cnts"}, 70'({pkt_cnt, err_cnt}), 70'(0));
      chk({tag, "_bytes"}, 70'(byte_cnt), 70'(0));
   endtask
   task automatic do_reset();
      rst_n = 1'b0; rx_if.val = 1'b0; rx_if.avail = 1'b0; out_if.ready = 1'b1; toggle = 1'b0;
      mq.delete(); expq.delete();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
   endtask
   initial begin
      int n;
      {rx_if.avail, rx_if.val, rx_if.data, rx_if.sop, rx_if.eop, rx_if.mod, rx_if.err} = '0;
      out_if.ready = 1'b1; toggle = 1'b0; mac_given = 0;
      do_reset();
      clear_stats();
      load_pkt(1, 8, 3'd0, -1);
      run_pkt("t1", 100);
      chk("t1_pkt", 70'(pkt_cnt), 70'(1));
      chk("t1_bytes", 70'(byte_cnt), 70'(64));
      chk("t1_err", 70'(err_cnt), 70'(0));
      chk("t1_ren_cnt", 70'(ren_cnt), 70'(8));
      chk("t1_ren_run", 70'(max_run), 70'(8));
      chk("t1_latency", 70'(first_out - first_ren), 70'(2));
      chk("t1_pops", 70'(pops), 70'(8));
      clear_stats();
      load_pkt(2, 8, 3'd5, -1);
      run_pkt("t2", 100);
      chk("t2_mod", 70'(last_mod), 70'(5));
      chk("t2_bytes", 70'(byte_cnt), 70'(125));
      chk("t2_pkt", 70'(pkt_cnt), 70'(2));
      clear_stats();
      toggle = 1'b1;
      load_pkt(3, 10, 3'd0, -1);
      load_pkt(4, 10, 3'd0, -1);
      run_pkt("t3", 300);
      toggle = 1'b0;
      chk("t3_pops", 70'(pops), 70'(20));
      chk("t3_ren_cnt", 70'(ren_cnt), 70'(20));
      chk("t3_pkt", 70'(pkt_cnt), 70'(4));
      chk("t3_bytes", 70'(byte_cnt), 70'(285));
      clear_stats();
      load_pkt(5, 10, 3'd0, 3);
      run_pkt("t4", 100);
      chk("t4_err_words", 70'(err_pops), 70'(2));
      chk("t4_err_cnt", 70'(err_cnt), 70'(1));
      chk("t4_pkt", 70'(pkt_cnt), 70'(5));
      chk("t4_bytes", 70'(byte_cnt), 70'(365));
      do_reset();
      clear_stats();
      load_pkt(6, 200, 3'd0, -1);
      run_pkt("t5", 1000);
      chk("t5_pops", 70'(pops), 70'(190));
      chk("t5_eop_err", 70'(last_err), 70'(1));
      chk("t5_bytes", 70'(byte_cnt), 70'(1600));
      chk("t5_err_cnt", 70'(err_cnt), 70'(1));
      chk("t5_pkt", 70'(pkt_cnt), 70'(1));
      clear_stats();
      mac_given = 0;
      load_pkt(7, 10, 3'd0, -1);
      n = 0;
      while (mac_given < 3 && n < 50) begin tick(); n++; end
      chk("t6_three_words", 70'(mac_given), 70'(3));
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      rx_if.val = 1'b0; rx_if.avail = 1'b0; mq.delete(); expq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      {rx_if.data, rx_if.sop, rx_if.eop, rx_if.mod, rx_if.err} = {64'hDEAD_BEEF, 1'b1, 1'b1, 3'd3, 1'b1};
      rx_if.val = 1'b1;
      repeat (3) tick();
      chk("stray_valid", 70'(out_if.val), 70'(0));
      chk("stray_bytes", 70'(byte_cnt), 70'(0));
      chk("stray_pkt", 70'(pkt_cnt), 70'(0));
      clear_stats();
      load_pkt(8, 8, 3'd0, -1);
      run_pkt("t6", 100);
      chk("t6_pkt", 70'(pkt_cnt), 70'(1));
      chk("t6_bytes", 70'(byte_cnt), 70'(64));
      chk("t6_err", 70'(err_cnt), 70'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
